mario_motion_ctrl: RTL and testbench
====================================

// Module: mario_motion_ctrl
// PURPOSE
//  Per-frame Mario motion controller; sits directly upstream of the Mario sprite-draw stage.
//  Turns button inputs into Mario's top-left screen position (curr_h, curr_v) and a 2-bit sprite select.
//  Covers walking, jump/gravity physics and walk animation. The draw stage consumes these outputs combinationally every pixel.
// PARAMETERS
//  START_H    150  reset/spawn horizontal position (px, top-left)
//  START_V    390  reset/spawn vertical position (px, top-left)
//  GROUND_V   390  landing row for curr_v
//  SPRITE_W   32   sprite width, used for right-edge clamp
//  SCREEN_W   640  visible width
//  WALK_STEP  2    px per frame while walking / airborne
//  JUMP_V     8    initial upward velocity (px/frame)
//  MAX_FALL   8    fall velocity cap (px/frame)
//  ANIM_DIV   4    frames per walk-animation toggle
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  frame_tick   in   1   one-cycle pulse per frame (vsync start); all motion updates gated by it
//  btn_left     in   1   level, walk left
//  btn_right    in   1   level, walk right
//  btn_jump     in   1   level, jump (edge-detected per frame)
//  curr_h       out  10  Mario top-left x
//  curr_v       out  10  Mario top-left y
//  sprite_selec out  2   0=stand 1=walkA 2=walkB 3=jump
//  facing_left  out  1   1 = mirror sprite
// BEHAVIOUR
//  - Reset (async): curr_h=START_H, curr_v=START_V, sprite_selec=0, facing_left=0. Reset also sets state=IDLE, vel=0, jump_prev=0 and clears the anim counter.
//  - All state and outputs are registered. They change only on the clk edge where frame_tick=1; output latency is 1 cycle after the tick.
//  - frame_tick asserted during reset is ignored.
//  - Horizontal direction dir:
//      left&&!right -> -1; right&&!left -> +1; both or neither -> 0.
//  - Horizontal saturation: curr_h clamps to [0, SCREEN_W-SPRITE_W] = [0, 608] and never wraps.
//  - facing_left updates only when dir!=0 and state is IDLE or WALK.
//  - FSM states: IDLE, WALK, JUMP_UP, FALL.
//    IDLE/WALK: dir!=0 -> WALK, else IDLE. Ground motion applies dir*WALK_STEP.
//    Jump edge = btn_jump && !jump_prev; jump_prev is sampled on every frame_tick.
//    IDLE/WALK + jump edge -> JUMP_UP, vel=JUMP_V, air_dir latched from the current dir.
//      Jump has priority over walking in the same frame, but the horizontal step for that frame still applies.
//    JUMP_UP, per tick:
//      curr_v -= vel; vel -= 1; curr_h += air_dir*WALK_STEP (saturating).
//      vel==1 before the update -> FALL with vel=0.
//      If curr_v < vel: curr_v=0, go FALL with vel=0.
//    FALL, per tick:
//      vel = min(vel+1, MAX_FALL), then curr_v += vel; air motion as in JUMP_UP.
//      If curr_v+vel >= GROUND_V: curr_v=GROUND_V, go IDLE or WALK per dir, air_dir cleared.
//  - A held btn_jump never retriggers; a new press is required after release.
//  - Jump edges arriving in JUMP_UP/FALL are discarded.
//  - sprite_selec:
//      IDLE=0. JUMP_UP/FALL=3.
//      WALK alternates 1,2, toggling every ANIM_DIV ticks and starting at 1 on WALK entry.
//      The landing tick outputs the destination state's code.
//  - Arithmetic: use 11-bit intermediates for h/v so clamps are detected before truncation. vel is 4 bits unsigned.
// CONFIGURATION
//  MARIO_LADDER_EN defined:
//    Adds ports btn_up, btn_down, on_ladder (in, 1 each) and state CLIMB.
//    IDLE/WALK + on_ladder + btn_up -> CLIMB.
//    CLIMB, per tick: curr_v -= 2 on up, += 2 on down (down clamps at GROUND_V); no horizontal motion.
//    sprite_selec alternates 1/2 on movement. Jump is ignored in CLIMB.
//    Exits: on_ladder deasserts -> FALL with vel=0; reaching GROUND_V with btn_down -> IDLE.
//  MARIO_LADDER_EN undefined: those ports and the CLIMB state do not exist. Behaviour is as above.
// STRUCTURE
//  mario_pkg holds:
//    - state enum (mario_state_t);
//    - sprite codes SPR_STAND/SPR_WALK_A/SPR_WALK_B/SPR_JUMP;
//    - SCREEN_W/SCREEN_H constants.
//  Sub-module mario_anim_counter: frame-tick divider with clear, outputs walk_phase (1 bit).
//  Top level contains the FSM, the physics datapath and the jump edge detector.
// TESTING
//  1. Pulse reset, no ticks -> curr=(150,390), sprite_selec=0, facing_left=0.
//  2. Hold btn_right, 3 frame_ticks -> curr_h=156, sprite_selec=1; after tick 4 -> sprite_selec=2.
//  3. Hold btn_left 100 ticks from reset -> curr_h saturates at 0. Then btn_right 400 ticks -> curr_h=608 and holds.
//  4. Tap btn_jump (no dir) -> curr_v 382,375,...,354 after 8 ticks; falls back to 390 after 8 more ticks.
//     sprite_selec=3 for ticks 1-15, 0 on the landing tick.
//  5. Hold btn_jump for 40 ticks -> exactly one jump; release then press -> second jump starts.
//     Both buttons pressed -> curr_h unchanged.
//  6. Assert reset mid-jump (curr_v=360) between clk edges -> outputs return to (150,390), sprite 0, without a clk edge.

Source files
------------

// File: rtl/mario_pkg.sv
// mario_pkg: shared types and constants for the Mario motion controller.
//   mario_state_t  motion FSM state (CLIMB exists only when MARIO_LADDER_EN is defined)
//   SPR_*          2-bit sprite select codes consumed by the sprite-draw stage
//   SCREEN_W/H     visible screen size in pixels
package mario_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    JUMP_UP = 3'd2,
    FALL    = 3'd3
`ifdef MARIO_LADDER_EN
    ,
    CLIMB   = 3'd4
`endif
  } mario_state_t;

  localparam logic [1:0] SPR_STAND  = 2'd0;
  localparam logic [1:0] SPR_WALK_A = 2'd1;
  localparam logic [1:0] SPR_WALK_B = 2'd2;
  localparam logic [1:0] SPR_JUMP   = 2'd3;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/mario_anim_counter.sv
// mario_anim_counter: frame-tick divider driving the walk animation phase.
//   clk, reset   clock, asynchronous active-high reset
//   tick         frame strobe; the counter only moves on ticks
//   clr          on a tick, return to phase 0 with an empty count
//   en           on a tick (without clr), count this frame; toggle the
//                phase after every ANIM_DIV counted frames
//   walk_phase   0 = walk frame A, 1 = walk frame B
module mario_anim_counter #(
  parameter int ANIM_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  input  logic en,
  output logic walk_phase
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(ANIM_DIV - 1);

  logic [CW-1:0] cnt;

  // The entry frame is counted, so phase A lasts ANIM_DIV-1 visible
  // frames after entry and every later phase lasts ANIM_DIV frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      walk_phase <= 1'b0;
    end else if (tick) begin
      if (clr) begin
        cnt        <= '0;
        walk_phase <= 1'b0;
      end else if (en) begin
        if (cnt == LAST) begin
          cnt        <= '0;
          walk_phase <= ~walk_phase;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mario_motion_ctrl.sv
// mario_motion_ctrl: per-frame Mario motion controller feeding the sprite-draw stage.
//   clk, reset        clock, asynchronous active-high reset
//   frame_tick        one-cycle pulse per frame; all state advances only on it
//   btn_left/right    walk direction levels (both or neither = stand still)
//   btn_jump          jump level, rising edge detected frame to frame
//   curr_h, curr_v    Mario top-left position in pixels
//   sprite_selec      0 stand, 1 walk A, 2 walk B, 3 jump
//   facing_left       1 = draw sprite mirrored
// Optional feature: define MARIO_LADDER_EN to add btn_up, btn_down, on_ladder
// and the CLIMB state.
module mario_motion_ctrl #(
  parameter int START_H   = 150,
  parameter int START_V   = 390,
  parameter int GROUND_V  = 390,
  parameter int SPRITE_W  = 32,
  parameter int SCREEN_W  = mario_pkg::SCREEN_W,
  parameter int WALK_STEP = 2,
  parameter int JUMP_V    = 8,
  parameter int MAX_FALL  = 8,
  parameter int ANIM_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
`ifdef MARIO_LADDER_EN
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       on_ladder,
`endif
  output logic [9:0] curr_h,
  output logic [9:0] curr_v,
  output logic [1:0] sprite_selec,
  output logic       facing_left
);

  import mario_pkg::*;

  localparam logic signed [10:0] H_MAX_S  = 11'(SCREEN_W - SPRITE_W);
  localparam logic signed [10:0] STEP_S   = 11'(WALK_STEP);
  localparam logic [10:0]        GROUND_X = 11'(GROUND_V);
  localparam logic [3:0]         JUMP_VEL = 4'(JUMP_V);
  localparam logic [3:0]         FALL_CAP = 4'(MAX_FALL);

  // Clamp a signed candidate x position into [0, SCREEN_W-SPRITE_W].
  function automatic logic [9:0] sat_h(input logic signed [10:0] x);
    if (x < 11'sd0)        sat_h = '0;
    else if (x > H_MAX_S)  sat_h = H_MAX_S[9:0];
    else                   sat_h = x[9:0];
  endfunction

  function automatic logic signed [10:0] step_of(input logic signed [1:0] d);
    if (d > 2'sd0)      step_of = STEP_S;
    else if (d < 2'sd0) step_of = -STEP_S;
    else                step_of = '0;
  endfunction

  mario_state_t      state, nxt_state;
  logic [3:0]        vel, nxt_vel, up_vel, fall_vel;
  logic signed [1:0] air_dir, nxt_air, dir;
  logic              jump_prev, jump_edge, nxt_face;
  logic [9:0]        nxt_h, nxt_v, ground_h, air_h;
  logic [10:0]       v_ext, fall_sum;
  logic              anim_en, anim_clr, walk_phase;

  // Input decode and shared arithmetic, all 11 bits wide so clamps are
  // detected before truncation back to 10-bit coordinates.
  always_comb begin
    dir = 2'sd0;
    if (btn_left && !btn_right)      dir = -2'sd1;
    else if (btn_right && !btn_left) dir = 2'sd1;
  end

  assign jump_edge = btn_jump && !jump_prev;
  assign ground_h  = sat_h(signed'({1'b0, curr_h}) + step_of(dir));
  assign air_h     = sat_h(signed'({1'b0, curr_h}) + step_of(air_dir));
  assign v_ext     = {1'b0, curr_v};
  assign fall_vel  = (vel >= FALL_CAP) ? FALL_CAP : vel + 4'd1;
  assign fall_sum  = v_ext + {7'd0, fall_vel};
  // The take-off frame already rises at full JUMP_V.
  assign up_vel    = (state == JUMP_UP) ? vel : JUMP_VEL;

  // Next-state and physics
  always_comb begin
    nxt_state = state;
    nxt_h     = curr_h;
    nxt_v     = curr_v;
    nxt_vel   = vel;
    nxt_air   = air_dir;
    nxt_face  = facing_left;
    case (state)
      IDLE, WALK: begin
        if (dir != 2'sd0) nxt_face = (dir < 2'sd0);
        nxt_h     = ground_h;
        nxt_state = (dir != 2'sd0) ? WALK : IDLE;
        if (jump_edge) begin
          nxt_air = dir;
          if (v_ext < {7'd0, up_vel}) begin
            nxt_v     = '0;
            nxt_vel   = '0;
            nxt_state = FALL;
          end else begin
            nxt_v     = curr_v - {6'd0, up_vel};
            nxt_vel   = (up_vel == 4'd1) ? 4'd0 : up_vel - 4'd1;
            nxt_state = (up_vel == 4'd1) ? FALL : JUMP_UP;
          end
        end
`ifdef MARIO_LADDER_EN
        if (on_ladder && btn_up) begin
          nxt_state = CLIMB;
          nxt_h     = curr_h;
          nxt_v     = curr_v;
          nxt_vel   = '0;
          nxt_air   = '0;
        end
`endif
      end
      JUMP_UP: begin
        nxt_h = air_h;
        if (v_ext < {7'd0, up_vel}) begin
          nxt_v     = '0;
          nxt_vel   = '0;
          nxt_state = FALL;
        end else begin
          nxt_v     = curr_v - {6'd0, up_vel};
          nxt_vel   = (up_vel == 4'd1) ? 4'd0 : up_vel - 4'd1;
          nxt_state = (up_vel == 4'd1) ? FALL : JUMP_UP;
        end
      end
      FALL: begin
        nxt_h = air_h;
        if (fall_sum >= GROUND_X) begin
          nxt_v     = GROUND_X[9:0];
          nxt_vel   = '0;
          nxt_air   = '0;
          nxt_state = (dir != 2'sd0) ? WALK : IDLE;
        end else begin
          nxt_v   = fall_sum[9:0];
          nxt_vel = fall_vel;
        end
      end
`ifdef MARIO_LADDER_EN
      CLIMB: begin
        if (!on_ladder) begin
          nxt_state = FALL;
          nxt_vel   = '0;
        end else if (btn_up && !btn_down) begin
          nxt_v = (curr_v < 10'd2) ? 10'd0 : curr_v - 10'd2;
        end else if (btn_down && !btn_up) begin
          if (v_ext + 11'd2 >= GROUND_X) begin
            nxt_v     = GROUND_X[9:0];
            nxt_state = IDLE;
          end else begin
            nxt_v = curr_v + 10'd2;
          end
        end
      end
`endif
      default: nxt_state = IDLE;
    endcase
  end

  // Frame-gated state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      curr_h      <= 10'(START_H);
      curr_v      <= 10'(START_V);
      vel         <= '0;
      air_dir     <= '0;
      facing_left <= 1'b0;
      jump_prev   <= 1'b0;
    end else if (frame_tick) begin
      state       <= nxt_state;
      curr_h      <= nxt_h;
      curr_v      <= nxt_v;
      vel         <= nxt_vel;
      air_dir     <= nxt_air;
      facing_left <= nxt_face;
      jump_prev   <= btn_jump;
    end
  end

  // Walk animation: counts while walking, restarts on any other state.
`ifdef MARIO_LADDER_EN
  assign anim_en  = (nxt_state == WALK) ||
                    ((nxt_state == CLIMB) && (btn_up != btn_down));
  assign anim_clr = (nxt_state != WALK) && (nxt_state != CLIMB);
`else
  assign anim_en  = (nxt_state == WALK);
  assign anim_clr = !anim_en;
`endif

  mario_anim_counter #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .clk        (clk),
    .reset      (reset),
    .tick       (frame_tick),
    .clr        (anim_clr),
    .en         (anim_en),
    .walk_phase (walk_phase)
  );

  // Sprite decode of registered state only, so it is stable all frame.
  always_comb begin
    sprite_selec = SPR_STAND;
    case (state)
      IDLE:          sprite_selec = SPR_STAND;
      WALK:          sprite_selec = walk_phase ? SPR_WALK_B : SPR_WALK_A;
      JUMP_UP, FALL: sprite_selec = SPR_JUMP;
`ifdef MARIO_LADDER_EN
      CLIMB:         sprite_selec = walk_phase ? SPR_WALK_B : SPR_WALK_A;
`endif
      default:       sprite_selec = SPR_STAND;
    endcase
  end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// tb_mario_motion_ctrl: scoreboard bench for mario_motion_ctrl (default build).
module tb_mario_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic [9:0] curr_h;
  logic [9:0] curr_v;
  logic [1:0] sprite_selec;
  logic       facing_left;

  always #5 clk = ~clk;

  mario_motion_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .curr_h       (curr_h),
    .curr_v       (curr_v),
    .sprite_selec (sprite_selec),
    .facing_left  (facing_left)
  );

  typedef struct {
    int h;
    int v;
    int spr;
    int face;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam int M_IDLE = 0, M_WALK = 1, M_UP = 2, M_FALL = 3;

  // Reference model state
  int m_st, m_h, m_v, m_vel, m_air, m_face, m_jprev, m_wn;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int clamp_h(input int x);
    if (x < 0)   return 0;
    if (x > 608) return 608;
    return x;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_h = 150; m_v = 390; m_vel = 0;
    m_air = 0; m_face = 0; m_jprev = 0; m_wn = 0;
  endtask

  task automatic model_rise();
    if (m_v < m_vel) begin
      m_v = 0; m_vel = 0; m_st = M_FALL;
    end else begin
      m_v = m_v - m_vel;
      if (m_vel == 1) begin m_vel = 0; m_st = M_FALL; end
      else begin m_vel = m_vel - 1; m_st = M_UP; end
    end
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    int d, fv;
    d = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    case (m_st)
      M_IDLE, M_WALK: begin
        if (d != 0) m_face = (d < 0) ? 1 : 0;
        m_h = clamp_h(m_h + 2 * d);
        if (j && !m_jprev) begin
          m_air = d; m_vel = 8;
          model_rise();
        end else begin
          m_st = (d != 0) ? M_WALK : M_IDLE;
        end
      end
      M_UP: begin
        m_h = clamp_h(m_h + 2 * m_air);
        model_rise();
      end
      default: begin
        m_h = clamp_h(m_h + 2 * m_air);
        fv = (m_vel + 1 > 8) ? 8 : m_vel + 1;
        if (m_v + fv >= 390) begin
          m_v = 390; m_vel = 0; m_air = 0;
          m_st = (d != 0) ? M_WALK : M_IDLE;
        end else begin
          m_v = m_v + fv; m_vel = fv;
        end
      end
    endcase
    m_wn = (m_st == M_WALK) ? m_wn + 1 : 0;
    m_jprev = j;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.h = m_h; e.v = m_v; e.face = m_face;
    if (m_st == M_IDLE)      e.spr = 0;
    else if (m_st == M_WALK) e.spr = (((m_wn / 4) % 2) != 0) ? 2 : 1;
    else                     e.spr = 3;
    return e;
  endfunction

  // One clock: drive inputs, push the expectation, compare after the edge.
  task automatic cycle(input bit tk, input bit l, input bit r, input bit j);
    exp_t e;
    @(negedge clk);
    frame_tick = tk; btn_left = l; btn_right = r; btn_jump = j;
    if (tk) model_tick(l, r, j);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("sb_h", int'(curr_h), e.h);
      check("sb_v", int'(curr_v), e.v);
      check("sb_spr", int'(sprite_selec), e.spr);
      check("sb_face", int'(facing_left), e.face);
    end
  endtask

  task automatic frame(input bit l, input bit r, input bit j);
    cycle(1'b1, l, r, j);
    cycle(1'b0, l, r, j);
  endtask

  // Reset with frame_tick and buttons active across the edge: must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_tick = 1'b1; btn_right = 1'b1; btn_jump = 1'b1;
    @(posedge clk);
    #1;
    check("rst_h", int'(curr_h), 150);
    check("rst_v", int'(curr_v), 390);
    check("rst_spr", int'(sprite_selec), 0);
    check("rst_face", int'(facing_left), 0);
    @(negedge clk);
    frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int vtab[16];
    int jumps;
    bit on_ground;
    vtab = '{382, 375, 369, 364, 360, 357, 355, 354,
             355, 357, 360, 364, 369, 375, 382, 390};

    // 1: reset state
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // 2: walk right, animation phase change on tick 4
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b1, 1'b0);
    check("t2_h3", int'(curr_h), 156);
    check("t2_spr3", int'(sprite_selec), 1);
    frame(1'b0, 1'b1, 1'b0);
    check("t2_spr4", int'(sprite_selec), 2);

    // 3: left saturation then right saturation
    do_reset();
    for (int i = 0; i < 100; i++) frame(1'b1, 1'b0, 1'b0);
    check("t3_hmin", int'(curr_h), 0);
    check("t3_face_l", int'(facing_left), 1);
    for (int i = 0; i < 400; i++) frame(1'b0, 1'b1, 1'b0);
    check("t3_hmax", int'(curr_h), 608);
    check("t3_face_r", int'(facing_left), 0);

    // 4: tapped jump arc
    do_reset();
    for (int k = 0; k < 16; k++) begin
      frame(1'b0, 1'b0, k == 0);
      check("t4_v", int'(curr_v), vtab[k]);
      check("t4_spr", int'(sprite_selec), (k < 15) ? 3 : 0);
    end

    // 5: held jump triggers once, re-press triggers again, both dirs cancel
    do_reset();
    jumps = 0;
    on_ground = 1'b1;
    for (int i = 0; i < 40; i++) begin
      frame(1'b0, 1'b0, 1'b1);
      if (curr_v != 10'd390 && on_ground) jumps++;
      on_ground = (curr_v == 10'd390);
    end
    check("t5_one_jump", jumps, 1);
    check("t5_v_ground", int'(curr_v), 390);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    check("t5_rejump_v", int'(curr_v), 382);
    for (int i = 0; i < 15; i++) frame(1'b0, 1'b0, 1'b0);
    check("t5_land_v", int'(curr_v), 390);
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b1, 1'b0);
    check("t5_both_h", int'(curr_h), 150);

    // Jump while walking right: air step keeps going
    for (int i = 0; i < 16; i++) frame(1'b0, 1'b1, i == 0);

    // 6: asynchronous reset mid-jump
    do_reset();
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b0, i == 0);
    check("t6_v_mid", int'(curr_v), 360);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_h", int'(curr_h), 150);
    check("t6_async_v", int'(curr_v), 390);
    check("t6_async_spr", int'(sprite_selec), 0);
    check("t6_async_face", int'(facing_left), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    frame(1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
